// File: rtl/rosc_loop_ctrl_if.sv
// Word delivery channel from the entropy loop sequencer to its consumer.
// The producer holds data/data_valid until the consumer raises data_ack.
interface rosc_loop_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ack;

  modport master (
    output data,
    output data_valid,
    input  data_ack
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ack
  );
endinterface

// File: rtl/rosc_loop_ctrl.sv
// Sequencer for a bank of ring-oscillator entropy loops. Seeds the loops,
// lets them free-run, samples their XOR through a 2-flop synchroniser,
// packs raw bits MSB-first into words and flags a stuck source.
module rosc_loop_ctrl #(
  parameter int NUM_LOOPS   = 8,
  parameter int SEED_CYCLES = 4,
  parameter int RUN_CYCLES  = 64,
  parameter int WORD_WIDTH  = 32,
  parameter int STUCK_LIMIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  output logic                 o_loop_ctrl,
  output logic                 o_loop_seed,
  input  logic [NUM_LOOPS-1:0] i_loop_d,
  output logic                 o_error,
  rosc_loop_ctrl_if.master     io_bus
);

  // One shared phase counter serves both SEED and RUN.
  localparam int CYC_MAX = (SEED_CYCLES > RUN_CYCLES) ? SEED_CYCLES : RUN_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int BIT_W   = $clog2(WORD_WIDTH);
  localparam int STK_W   = $clog2(STUCK_LIMIT + 1);

  localparam logic [CYC_W-1:0] SEED_LAST = CYC_W'(SEED_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [STK_W-1:0] STK_LIM   = STK_W'(STUCK_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  state_t                r_state;
  logic [CYC_W-1:0]      r_cyc;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [WORD_WIDTH-1:0] r_word;
  logic [STK_W-1:0]      r_stk_cnt;
  logic                  r_prev;
  logic [NUM_LOOPS-1:0]  r_sync1;
  logic [NUM_LOOPS-1:0]  r_sync2;
  logic                  r_loop_ctrl;
  logic                  r_loop_seed;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_data_valid;
  logic                  r_error;

  state_t                w_next_state;
  logic [CYC_W-1:0]      w_cyc_nxt;
  logic [BIT_W-1:0]      w_bit_cnt_nxt;
  logic [WORD_WIDTH-1:0] w_word_nxt;
  logic [WORD_WIDTH-1:0] w_word_shift;
  logic [STK_W-1:0]      w_stk_nxt;
  logic [STK_W-1:0]      w_stk_inc;
  logic                  w_prev_nxt;
  logic                  w_ctrl_nxt;
  logic                  w_seed_nxt;
  logic [WORD_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_error_nxt;
  logic                  w_raw;

  // Two-flop synchroniser for the asynchronous loop outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_loop_d;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, datapath and registered-output values for the sequencer.
  always_comb begin
    w_next_state  = r_state;
    w_cyc_nxt     = r_cyc;
    w_bit_cnt_nxt = r_bit_cnt;
    w_word_nxt    = r_word;
    w_stk_nxt     = r_stk_cnt;
    w_prev_nxt    = r_prev;
    w_seed_nxt    = r_loop_seed;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_data_valid;
    w_error_nxt   = r_error;
    w_raw         = ^r_sync2;
    w_word_shift  = {r_word[WORD_WIDTH-2:0], w_raw};
    if (r_stk_cnt == STK_LIM) begin
      w_stk_inc = r_stk_cnt;
    end else begin
      w_stk_inc = r_stk_cnt + STK_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        // A zero stuck count marks the next sample as the first after idle.
        w_bit_cnt_nxt = '0;
        w_stk_nxt     = '0;
        if (i_enable) begin
          w_next_state = ST_SEED;
          w_seed_nxt   = ~r_loop_seed;
          w_cyc_nxt    = '0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SEED: begin
        if (!i_enable) begin
          w_next_state = ST_IDLE;
        end else if (r_cyc == SEED_LAST) begin
          w_next_state = ST_RUN;
          w_cyc_nxt    = '0;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          w_next_state = ST_IDLE;
        end else if (r_cyc == RUN_LAST) begin
          w_next_state = ST_SAMPLE;
          w_cyc_nxt    = '0;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (!i_enable) begin
          w_next_state = ST_IDLE;
        end else begin
          w_word_nxt = w_word_shift;
          if ((r_stk_cnt == '0) || (w_raw != r_prev)) begin
            w_stk_nxt = STK_W'(1);
          end else begin
            w_stk_nxt = w_stk_inc;
          end
          w_prev_nxt  = w_raw;
          w_error_nxt = r_error | (w_stk_nxt == STK_LIM);
          if (r_bit_cnt == BIT_LAST) begin
            w_next_state  = ST_OUTPUT;
            w_data_nxt    = w_word_shift;
            w_valid_nxt   = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_next_state  = ST_RUN;
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            w_cyc_nxt     = '0;
          end
        end
      end
      ST_OUTPUT: begin
        // The word is held regardless of enable until the consumer takes it.
        if (r_data_valid && io_bus.data_ack) begin
          w_valid_nxt = 1'b0;
          if (i_enable) begin
            w_next_state = ST_SEED;
            w_seed_nxt   = ~r_loop_seed;
            w_cyc_nxt    = '0;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_OUTPUT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_valid_nxt  = 1'b0;
      end
    endcase

    // Loops are held whenever the sequencer is not letting them oscillate.
    w_ctrl_nxt = (w_next_state == ST_IDLE) || (w_next_state == ST_SEED) ||
                 (w_next_state == ST_OUTPUT);
  end

  // State register and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_stk_cnt    <= '0;
      r_prev       <= 1'b0;
      r_loop_ctrl  <= 1'b1;
      r_loop_seed  <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cyc        <= w_cyc_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_word       <= w_word_nxt;
      r_stk_cnt    <= w_stk_nxt;
      r_prev       <= w_prev_nxt;
      r_loop_ctrl  <= w_ctrl_nxt;
      r_loop_seed  <= w_seed_nxt;
      r_data       <= w_data_nxt;
      r_data_valid <= w_valid_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign o_loop_ctrl       = r_loop_ctrl;
  assign o_loop_seed       = r_loop_seed;
  assign o_error           = r_error;
  assign io_bus.data       = r_data;
  assign io_bus.data_valid = r_data_valid;

endmodule

// File: doc/rosc_loop_ctrl.md
Name: rosc_loop_ctrl

Overview:
Sequencer for a bank of inverter-ring entropy loops, each with a ctrl/seed input pair and a free-running output d. Alternates seed and run phases on all loops and samples their outputs through a synchroniser. Each sample's outputs are XOR-reduced to one raw bit, and the bits are packed into words for a downstream consumer over a valid/ack handshake. Also flags a stuck source. Sits between the loop bank and the entropy post-processing / mixer logic.

Parameters:
NUM_LOOPS, 8, number of loops driven and sampled (>=1)
SEED_CYCLES, 4, cycles loop_ctrl is held high per seed phase (>=1)
RUN_CYCLES, 64, free-run cycles between samples (>=1)
WORD_WIDTH, 32, raw bits packed per output word (>=2)
STUCK_LIMIT, 16, identical consecutive raw bits that set error (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  run request; level sensitive
loop_ctrl  out  1  shared ctrl to all loops; 1 = seed/hold, 0 = oscillate
loop_seed  out  1  shared seed value to all loops
loop_d  in  NUM_LOOPS  loop outputs; asynchronous to clk
data  out  WORD_WIDTH  packed raw word
data_valid  out  1  data holds a complete word
data_ack  in  1  consumer accepts data; sampled only while data_valid=1
error  out  1  sticky stuck-source flag

Behaviour:
- Reset values, and all registers, on any cycle with reset=1, including mid-operation:
  - Registers cleared: state=IDLE, loop_ctrl=1, loop_seed=0, data=0, data_valid=0, error=0, bit count=0, stuck count=0, previous-bit=0, synchroniser flops=0.
- loop_d passes through a 2-flop synchroniser per bit. The raw bit is the XOR of all synchronised bits at the SAMPLE cycle.
- All outputs are registered.
- FSM states: IDLE, SEED, RUN, SAMPLE, OUTPUT.
  - IDLE: loop_ctrl=1. If enable=1, go to SEED next cycle and toggle loop_seed.
  - SEED: loop_ctrl=1 for exactly SEED_CYCLES cycles, then RUN.
  - RUN: loop_ctrl=0 for exactly RUN_CYCLES cycles, then SAMPLE.
  - SAMPLE: loop_ctrl=0, one cycle.
    - Update word: word <= {word[WORD_WIDTH-2:0], raw}, so the MSB is the oldest bit. Increment bit count.
    - If this was bit WORD_WIDTH: the next cycle is OUTPUT with data=word, data_valid=1, bit count=0. Otherwise the next state is RUN (no reseed between bits).
  - OUTPUT: loop_ctrl=1 (loops halted); data and data_valid stay stable until data_ack=1.
    - The cycle after ack: data_valid=0.
    - Next state is SEED (loop_seed toggled) if enable=1, else IDLE.
- enable=0 in SEED/RUN/SAMPLE: next cycle is IDLE with loop_ctrl=1; the partial word and bit count are discarded.
- enable=0 in OUTPUT: the pending word is still held until acked, then the FSM goes to IDLE.
- data_ack while data_valid=0 is ignored.
- Stuck detection, evaluated at each SAMPLE:
  - If raw equals previous-bit, increment the stuck count (saturating); else reset it to 1. Then previous-bit <= raw.
  - The first sample after IDLE sets the count to 1.
  - error <= 1 when the count reaches STUCK_LIMIT. error clears only on reset; word production continues.
- Latency from enable=1 in IDLE to the first data_valid: 1 + SEED_CYCLES + WORD_WIDTH*(RUN_CYCLES+1) cycles.
- Bit count and cycle counter widths: clog2 of their limits. The bit count never wraps without producing a word.

Test Plan:
Common parameters: NUM_LOOPS=2, SEED_CYCLES=2, RUN_CYCLES=3, WORD_WIDTH=4, STUCK_LIMIT=4. Cycle 0 is the first cycle with enable=1 after reset.
1. Reset, then enable=1 at cycle 0; bench presents loop_d so raw bits are 1,0,1,1 at SAMPLE cycles 6, 10, 14, 18 (loop_d stable >=3 cycles before each) -> loop_ctrl=1 in cycles 1-2 and 0 in 3-18; loop_seed=1 from cycle 1; data_valid=1 at cycle 19 with data=4'hB; error=0.
2. Hold data_ack=0 for 5 cycles after valid, then pulse data_ack=1 -> data stays 4'hB and loop_ctrl=1 throughout; data_valid=0 the cycle after ack; SEED is re-entered with loop_seed=0.
3. loop_d held at 2'b01 constantly -> raw=1 every sample; error=1 the cycle after the 4th SAMPLE (cycle 19) and stays set; data=4'hF still delivered.
4. enable dropped to 0 at cycle 12, mid-word -> IDLE at cycle 13, loop_ctrl=1, no data_valid. Re-enable -> the next word has 4 fresh bits; the bit count restarts at 0.
5. reset asserted during OUTPUT with error=1 -> next cycle: data_valid=0, data=0, error=0, loop_ctrl=1, loop_seed=0, state IDLE.
6. data_ack=1 held while in RUN (data_valid=0) -> no state effect; the following word handshakes normally.
